// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int          SEG_DIGITS    = 8;
  localparam logic [7:0]  SEG_ALL_OFF_N = 8'hFF;

endpackage

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered patterns.
// Registered outputs; each digit gets BLANK_CYC dark cycles then CLK_DIV lit cycles.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_a,
  input  logic [31:0] seg_b,
  input  logic        load,
  input  logic        clear,
  output logic [7:0]  seg_n,
  output logic [7:0]  digit_sel_n,
  output logic        frame_tick
);

  localparam int MAX_CYC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(SEG_DIGITS);
  localparam int BUF_W   = SEG_DIGITS * 8;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SEG_DIGITS - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] pending_q, pending_d;
  logic [BUF_W-1:0] active_q, active_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic [7:0]       digit_sel_n_q, digit_sel_n_d;
  logic             frame_tick_q, frame_tick_d;
  logic             boundary;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 1'b1;
          boundary = (idx_q == IDX_LAST);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    // frame_tick_q marks the boundary update cycle: a load there bypasses to active.
    pending_d = pending_q;
    active_d  = active_q;
    if (boundary) begin
      active_d = pending_q;
    end
    if (load) begin
      pending_d = {seg_b, seg_a};
      if (frame_tick_q) begin
        active_d = {seg_b, seg_a};
      end
    end
    if (clear) begin
      pending_d = '0;
      active_d  = '0;
    end

    // Outputs are computed from next state so they move on the same edge as the FSM.
    seg_n_d       = SEG_ALL_OFF_N;
    digit_sel_n_d = SEG_ALL_OFF_N;
    frame_tick_d  = boundary;
    if (state_d == SHOW) begin
      digit_sel_n_d = ~(8'h01 << idx_d);
      seg_n_d       = ~active_d[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      seg_n_q       <= SEG_ALL_OFF_N;
      digit_sel_n_q <= SEG_ALL_OFF_N;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      seg_n_q       <= seg_n_d;
      digit_sel_n_q <= digit_sel_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign digit_sel_n = digit_sel_n_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with CLK_DIV=4, BLANK_CYC=2 (P=6, frame=48).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seg_a;
  logic [31:0] seg_b;
  logic        load;
  logic        clear;
  logic [7:0]  seg_n;
  logic [7:0]  digit_sel_n;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [63:0] PAT_A = 64'h7F077D6D_4F5B0666;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .CLK_DIV   (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_a       (seg_a),
    .seg_b       (seg_b),
    .load        (load),
    .clear       (clear),
    .seg_n       (seg_n),
    .digit_sel_n (digit_sel_n),
    .frame_tick  (frame_tick)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Holds rst for n edges; the cycle after release is cycle 0.
  task automatic do_reset(input int n);
    rst   = 1'b1;
    load  = 1'b0;
    clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Expected outputs for the current cycle given the pattern that should be active.
  task automatic check_cycle(input logic [63:0] act);
    int         p;
    int         d;
    logic [7:0] oh;
    logic [7:0] exp_d;
    logic [7:0] exp_s;
    logic [7:0] exp_f;
    p  = cyc % 6;
    d  = (cyc / 6) % 8;
    oh = 8'h01 << d;
    if (p < 2) begin
      exp_d = 8'hFF;
      exp_s = 8'hFF;
    end else begin
      exp_d = ~oh;
      exp_s = ~act[d*8 +: 8];
    end
    exp_f = (cyc > 0 && (cyc % 48) == 0) ? 8'h01 : 8'h00;
    chk("dsel", digit_sel_n, exp_d);
    chk("seg", seg_n, exp_s);
    chk("ftick", {7'b0, frame_tick}, exp_f);
    if (p >= 2) chk("one_cold", 8'($countones(~digit_sel_n)), 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    clear = 1'b0;
    seg_a = '0;
    seg_b = '0;

    // Reset, scan order, double buffering, three-frame wrap
    do_reset(3);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_dsel", digit_sel_n, 8'hFF);
    chk("rst_ftick", {7'b0, frame_tick}, 8'h00);
    for (int c = 0; c < 144; c++) begin
      goto(c);
      if (c == 10) begin
        load  = 1'b1;
        seg_a = 32'h4F5B0666;
        seg_b = 32'h7F077D6D;
      end else begin
        load = 1'b0;
      end
      check_cycle(c < 48 ? 64'h0 : PAT_A);
      if (c >= 2 && c <= 5) chk("d0_show_dsel", digit_sel_n, 8'hFE);
      if (c == 8) chk("d1_dsel", digit_sel_n, 8'hFD);
      if (c == 48) chk("ftick_48", {7'b0, frame_tick}, 8'h01);
      if (c >= 50 && c <= 53) chk("dbuf_d0", seg_n, 8'h99);
      if (c >= 92 && c <= 95) chk("dbuf_d7", seg_n, 8'h80);
    end

    // Load on the boundary update cycle goes straight to active
    do_reset(2);
    for (int c = 0; c < 60; c++) begin
      goto(c);
      load = (c == 48);
      if (c == 48) begin
        seg_a = 32'h000000FF;
        seg_b = 32'h00000000;
      end
      check_cycle(c < 48 ? 64'h0 : 64'h00000000_000000FF);
      if (c >= 50 && c <= 53) chk("bnd_d0", seg_n, 8'h00);
    end
    load = 1'b0;

    // Clear beats a simultaneous load and empties both buffers
    do_reset(2);
    seg_a = PAT_A[31:0];
    seg_b = PAT_A[63:32];
    for (int c = 0; c < 144; c++) begin
      goto(c);
      load  = (c == 5) || (c == 60);
      clear = (c == 60);
      check_cycle((c >= 48 && c <= 60) ? PAT_A : 64'h0);
      if (c == 58) chk("pre_clr", seg_n, 8'hF9);
      if (c == 62) chk("clr_next_show", seg_n, 8'hFF);
    end
    load  = 1'b0;
    clear = 1'b0;

    // Reset mid-scan with both buffers holding non-zero data
    do_reset(2);
    seg_a = PAT_A[31:0];
    seg_b = PAT_A[63:32];
    for (int c = 0; c <= 78; c++) begin
      goto(c);
      load = (c == 5) || (c == 60);
      if (c == 60) begin
        seg_a = 32'h55667788;
        seg_b = 32'h11223344;
      end
      check_cycle(c < 48 ? 64'h0 : PAT_A);
      if (c == 74) chk("pre_rst_d4", seg_n, 8'h92);
    end
    do_reset(1);
    chk("mid_rst_seg", seg_n, 8'hFF);
    chk("mid_rst_dsel", digit_sel_n, 8'hFF);
    chk("mid_rst_ftick", {7'b0, frame_tick}, 8'h00);
    for (int c = 0; c < 60; c++) begin
      goto(c);
      check_cycle(64'h0);
      if (c == 48) chk("mid_rst_ftick48", {7'b0, frame_tick}, 8'h01);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
